// File: rtl/jk_bank_sequencer_if.sv
// Request, completion and bank-strobe bus of jk_bank_sequencer.
// The master drives requests and reports the bank state; the slave is the sequencer.
interface jk_bank_sequencer_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) ();
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ*2-1:0]    req_op;
  logic                 clr_start;
  logic                 clr_done;
  logic [WIDTH-1:0]     jk_j;
  logic [WIDTH-1:0]     jk_k;
  logic [WIDTH-1:0]     bank_q;
  logic                 done_valid;
  logic [2:0]           done_id;
  logic                 done_q;
  logic                 done_err;

  modport master (
    output req_valid, req_idx, req_op, clr_start, bank_q,
    input  req_ready, clr_done, jk_j, jk_k, done_valid, done_id, done_q, done_err
  );

  modport slave (
    input  req_valid, req_idx, req_op, clr_start, bank_q,
    output req_ready, clr_done, jk_j, jk_k, done_valid, done_id, done_q, done_err
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Round-robin sequencer sharing a bank of JK cells among NREQ requesters:
// grant at t, registered j/k strobe at t+1, completion with post-op q at t+2.
module jk_bank_sequencer #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic               clk,
  input  logic               reset,
  jk_bank_sequencer_if.slave bus
);
  localparam int          PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_W = (PW + 1)'(NREQ);

  typedef enum logic [1:0] {IDLE, CLR_DRIVE, CLR_WAIT} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;

  logic [NREQ-1:0]  valid_rot;
  logic [PW-1:0]    first_off;
  logic [PW:0]      grant_sum;
  logic [PW:0]      ptr_nxt;
  logic [PW-1:0]    grant_id;
  logic             grant;
  logic [NREQ-1:0]  ready;
  logic [IDXW-1:0]  sel_idx;
  logic [1:0]       sel_op;
  logic             sel_err;

  logic             s1_valid_q, s1_valid_d;
  logic [PW-1:0]    s1_id_q, s1_id_d;
  logic [IDXW-1:0]  s1_idx_q, s1_idx_d;
  logic             s1_err_q, s1_err_d;
  logic [WIDTH-1:0] jk_j_q, jk_j_d;
  logic [WIDTH-1:0] jk_k_q, jk_k_d;
  logic             clr_done_q, clr_done_d;

  logic             done_valid_q;
  logic [2:0]       done_id_q;
  logic [IDXW-1:0]  done_idx_q;
  logic             done_err_q;

  // Rotate valids so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    valid_rot = NREQ'({bus.req_valid, bus.req_valid} >> ptr_q);
    first_off = '0;
    for (int n = NREQ - 1; n >= 0; n--) begin
      if (valid_rot[n]) first_off = PW'(n);
    end
    grant_sum = {1'b0, ptr_q} + {1'b0, first_off};
    if (grant_sum >= NREQ_W) grant_sum = grant_sum - NREQ_W;
    grant_id = grant_sum[PW-1:0];
    ptr_nxt  = {1'b0, grant_id} + (PW + 1)'(1);
    if (ptr_nxt == NREQ_W) ptr_nxt = '0;
    sel_idx  = bus.req_idx[grant_id*IDXW +: IDXW];
    sel_op   = bus.req_op[grant_id*2 +: 2];
    sel_err  = 32'(sel_idx) >= 32'(WIDTH);
    grant    = (state_q == IDLE) && !bus.clr_start && !reset && (|bus.req_valid);
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    ready      = '0;
    s1_valid_d = 1'b0;
    s1_id_d    = grant_id;
    s1_idx_d   = sel_idx;
    s1_err_d   = sel_err;
    jk_j_d     = '0;
    jk_k_d     = '0;
    clr_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_start && !reset) begin
          state_d = CLR_DRIVE;
          jk_k_d  = '1;
        end else if (grant) begin
          ready      = NREQ'(1) << grant_id;
          ptr_d      = ptr_nxt[PW-1:0];
          s1_valid_d = 1'b1;
          if (!sel_err) begin
            jk_j_d = WIDTH'(sel_op[1]) << sel_idx;
            jk_k_d = WIDTH'(sel_op[0]) << sel_idx;
          end
        end
      end
      CLR_DRIVE: state_d = CLR_WAIT;
      CLR_WAIT: begin
        state_d    = IDLE;
        clr_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_idx_q     <= '0;
      s1_err_q     <= 1'b0;
      jk_j_q       <= '0;
      jk_k_q       <= '0;
      clr_done_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_idx_q   <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_idx_q     <= s1_idx_d;
      s1_err_q     <= s1_err_d;
      jk_j_q       <= jk_j_d;
      jk_k_q       <= jk_k_d;
      clr_done_q   <= clr_done_d;
      done_valid_q <= s1_valid_q;
      done_id_q    <= 3'(s1_id_q);
      done_idx_q   <= s1_idx_q;
      done_err_q   <= s1_err_q;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.jk_j       = jk_j_q;
  assign bus.jk_k       = jk_k_q;
  assign bus.clr_done   = clr_done_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_err   = done_err_q;
  // The strobe landed on the edge that started this cycle, so bank_q already holds the result.
  assign bus.done_q     = done_valid_q && !done_err_q &&
                          (|(bus.bank_q & (WIDTH'(1) << done_idx_q)));
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer: a JK bank model, a scoreboard queue filled
// at each handshake and a monitor that pops and compares every done pulse.
module tb_jk_bank_sequencer;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 4;

  typedef struct {
    int   id;
    logic q;
    logic err;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [WIDTH-1:0] bank = '0;
  logic             bank_load = 1'b0;
  logic [WIDTH-1:0] bank_load_val = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jk_bank_sequencer_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) bus ();

  jk_bank_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Bank of JK cells driven by the DUT strobes.
  always @(posedge clk) begin
    if (bank_load) bank <= bank_load_val;
    else begin
      for (int b = 0; b < WIDTH; b++) begin
        case ({bus.jk_j[b], bus.jk_k[b]})
          2'b01:   bank[b] <= 1'b0;
          2'b10:   bank[b] <= 1'b1;
          2'b11:   bank[b] <= ~bank[b];
          default: ;
        endcase
      end
    end
  end
  assign bus.bank_q = bank;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(int i, logic [IDXW-1:0] idx, logic [1:0] op);
    bus.req_idx[i*IDXW +: IDXW] = idx;
    bus.req_op[i*2 +: 2]        = op;
  endtask

  task automatic expect_done(int id, logic q, logic err);
    exp_t e;
    e.id  = id;
    e.q   = q;
    e.err = err;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest expectation, two cycles after its grant.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ready_without_valid", 32'(bus.req_ready & ~bus.req_valid), 0);
      if (bus.done_valid === 1'b1) begin
        check("done_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("done_id", 32'(bus.done_id), 32'(mon_e.id));
          check("done_q", 32'(bus.done_q), 32'(mon_e.q));
          check("done_err", 32'(bus.done_err), 32'(mon_e.err));
          check("done_latency", 32'(cyc), 32'(mon_e.cyc + 2));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_idx   = '0;
    bus.req_op    = '0;
    bus.clr_start = 1'b0;

    // Reset state
    step();
    sample();
    check("rst_strobes", {bus.jk_j, bus.jk_k}, 0);
    check("rst_ctrl", {bus.req_ready, bus.done_valid, bus.done_id, bus.done_q,
                       bus.done_err, bus.clr_done}, 0);
    step();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle for 5 cycles
    for (int k = 0; k < 5; k++) begin
      sample();
      check("idle_strobes", {bus.jk_j, bus.jk_k}, 0);
      check("idle_ctrl", {bus.req_ready, bus.done_valid, bus.done_id, bus.done_q,
                          bus.done_err, bus.clr_done}, 0);
      step();
    end

    // Requester 2 sets cell 5
    set_req(2, 4'd5, 2'b10);
    bus.req_valid = 4'b0100;
    sample();
    check("set_ready", 32'(bus.req_ready), 32'h4);
    expect_done(2, 1'b1, 1'b0);
    step();
    bus.req_valid = '0;
    sample();
    check("set_jk_j", 32'(bus.jk_j), 32'h20);
    check("set_jk_k", 32'(bus.jk_k), 32'h0);
    step();
    sample();
    check("set_strobe_one_cycle", {bus.jk_j, bus.jk_k}, 0);
    step();

    // Round robin: all four toggle their own cell for 8 cycles
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_req(i, IDXW'(i), 2'b11);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      sample();
      check("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      expect_done(k % 4, (k < 4), 1'b0);
      step();
    end
    bus.req_valid = '0;
    sample();
    step();
    sample();
    step();
    sample();
    check("rr_bank_restored", 32'(bus.bank_q[3:0]), 0);
    step();

    // Back-to-back toggles on cell 3, then an out-of-range index
    set_req(0, 4'd3, 2'b11);
    bus.req_valid = 4'b0001;
    sample();
    check("tgl1_ready", 32'(bus.req_ready), 32'h1);
    expect_done(0, 1'b1, 1'b0);
    step();
    sample();
    check("tgl2_ready", 32'(bus.req_ready), 32'h1);
    expect_done(0, 1'b0, 1'b0);
    step();
    set_req(0, 4'd9, 2'b10);
    sample();
    check("err_ready", 32'(bus.req_ready), 32'h1);
    expect_done(0, 1'b0, 1'b1);
    step();
    bus.req_valid = '0;
    sample();
    check("err_no_strobe", {bus.jk_j, bus.jk_k}, 0);
    step();
    sample();
    step();
    sample();
    step();

    // Bank clear with a competing request
    bank_load     = 1'b1;
    bank_load_val = 8'hFF;
    step();
    bank_load     = 1'b0;
    bus.clr_start = 1'b1;
    set_req(1, 4'd2, 2'b10);
    bus.req_valid = 4'b0010;
    sample();
    check("clr_no_grant", 32'(bus.req_ready), 0);
    check("clr_bank_full", 32'(bus.bank_q), 32'hFF);
    step();
    bus.clr_start = 1'b0;
    sample();
    check("clr_drive_ready", 32'(bus.req_ready), 0);
    check("clr_drive_jk_k", 32'(bus.jk_k), 32'hFF);
    check("clr_drive_jk_j", 32'(bus.jk_j), 0);
    check("clr_drive_done", 32'(bus.clr_done), 0);
    step();
    sample();
    check("clr_wait_ready", 32'(bus.req_ready), 0);
    check("clr_wait_jk_k", 32'(bus.jk_k), 0);
    check("clr_wait_done", 32'(bus.clr_done), 0);
    check("clr_wait_bank", 32'(bus.bank_q), 0);
    step();
    bus.req_valid = '0;
    sample();
    check("clr_done_pulse", 32'(bus.clr_done), 1);
    check("clr_bank_empty", 32'(bus.bank_q), 0);
    step();
    bus.req_valid = 4'b0010;
    sample();
    check("clr_done_one_cycle", 32'(bus.clr_done), 0);
    check("post_clr_grant", 32'(bus.req_ready), 32'h2);
    expect_done(1, 1'b1, 1'b0);
    step();
    bus.req_valid = '0;
    sample();
    step();
    sample();
    step();

    // Reset right after a grant: op discarded, pointer back to 0
    set_req(1, 4'd6, 2'b11);
    bus.req_valid = 4'b0010;
    sample();
    check("pre_rst_grant", 32'(bus.req_ready), 32'h2);
    step();
    bus.req_valid = '0;
    reset         = 1'b1;
    sample();
    step();
    reset = 1'b0;
    sample();
    check("post_rst_strobes", {bus.jk_j, bus.jk_k}, 0);
    check("post_rst_no_done", 32'(bus.done_valid), 0);
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, IDXW'(i), 2'b00);
    bus.req_valid = 4'b1111;
    sample();
    check("post_rst_ptr", 32'(bus.req_ready), 32'h1);
    expect_done(0, 1'b0, 1'b0);
    step();
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      sample();
      step();
    end

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Shares a bank of WIDTH single-bit JK flip-flop cells among NREQ requesters.
- Each request names one cell and one JK operation: hold, reset, set or toggle.
- The block arbitrates round-robin and issues one operation per cycle as registered j/k strobes to the bank.
- It reports completion with the cell's post-operation value, and provides a bank-wide clear sequence.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, number of JK cells in the bank (1..32).
- IDXW, 3, width of a cell index; must satisfy 2^IDXW >= WIDTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; transfer when valid&ready.
- req_idx  input  NREQ*IDXW  cell index, requester i at bits [i*IDXW +: IDXW].
- req_op  input  NREQ*2  op {j,k}, requester i at bits [2i +: 2]; 00 hold, 01 reset, 10 set, 11 toggle.
- clr_start  input  1  pulse: clear whole bank.
- clr_done  output  1  one-cycle pulse when clear completes.
- jk_j  output  WIDTH  registered j strobes to bank cells.
- jk_k  output  WIDTH  registered k strobes to bank cells.
- bank_q  input  WIDTH  current q of bank cells.
- done_valid  output  1  one-cycle completion pulse.
- done_id  output  3  requester id of completed op.
- done_q  output  1  bank_q[idx] after the op took effect.
- done_err  output  1  completed op had idx >= WIDTH.

Behaviour:
- Reset (synchronous, sampled at clk edge):
  - jk_j, jk_k, req_ready, done_valid, done_id, done_q, done_err and clr_done all 0.
  - Round-robin pointer is 0; FSM goes to IDLE; in-flight ops are discarded and produce no done pulse.
- FSM states: IDLE, CLR_DRIVE, CLR_WAIT.
- IDLE arbitration (combinational, cycle t):
  - Search req_valid starting at the pointer, wrapping modulo NREQ.
  - The first valid requester i gets req_ready[i]=1; all other req_ready bits are 0.
  - The pointer updates to (i+1) mod NREQ at the end of t.
  - With no valid request, req_ready is 0 and the pointer is unchanged.
  - req_ready never asserts without the matching req_valid.
- Issue (cycle t+1):
  - jk_j[idx]=op[1] and jk_k[idx]=op[0]; every other bit is 0.
  - Strobes last exactly one cycle and are all 0 in any cycle with no issue.
  - The hold op still occupies a slot and drives 00.
- Complete (cycle t+2):
  - done_valid=1, done_id=i, done_q=bank_q[idx].
  - Fixed latency: handshake to done is 2 cycles.
  - Pipelined: one grant per cycle sustained, in order.
- Same-cell back-to-back ops are legal; each sees the result of the previous one (e.g. two toggles return to the original value).
- idx >= WIDTH:
  - Grant proceeds and no strobe is driven.
  - At t+2: done_valid=1, done_err=1, done_q=0.
- clr_start in IDLE:
  - Takes priority over requests in the same cycle; no grant that cycle.
  - Next state is CLR_DRIVE: jk_k all 1, jk_j all 0, for one cycle.
  - Then CLR_WAIT for one cycle.
  - Then IDLE with clr_done=1 for that cycle.
- Requests during clear:
  - req_ready is 0 throughout CLR_DRIVE and CLR_WAIT.
  - Ops granted before the clear still complete normally; their strobes issue before CLR_DRIVE.
- clr_start while not in IDLE is ignored.

Test Plan:
- Reset, then hold all inputs idle 5 cycles -> all outputs 0, no strobes.
- Requester 2 sets idx 5 at t -> req_ready=0100 at t; jk_j=0x20, jk_k=0 at t+1; done_valid, done_id=2, done_q=1 at t+2.
- All 4 requesters valid for 8 cycles, each toggling its own cell -> grants 0,1,2,3,0,1,2,3; done pulses every cycle in the same order; each cell toggled twice, ends at its start value.
- Two consecutive toggles on cell 3 from q=0 -> done_q=1 then done_q=0. Then idx=9 with WIDTH=8 -> no strobe, done_err=1.
- Bank=0xFF, clr_start with requester 1 valid the same cycle -> no grant; jk_k=0xFF one cycle; clr_done two cycles later; bank reads 0x00; requester 1 granted the cycle after clr_done.
- Reset asserted the cycle after a grant -> strobes 0 and no done pulse; pointer is 0 again (requester 0 wins the next contention).
